// File: rtl/burrito_pkg.sv
// Shared definitions for the Burrito instruction sequencer: state encoding,
// instruction field positions and the HALT opcode encoding.
package burrito_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned WE_BIT  = 19;
  localparam int unsigned SEL_HI  = 18;
  localparam int unsigned SEL_LO  = 15;
  localparam int unsigned RR1_HI  = 14;
  localparam int unsigned RR1_LO  = 10;
  localparam int unsigned RR2_HI  = 9;
  localparam int unsigned RR2_LO  = 5;
  localparam int unsigned AW_HI   = 4;
  localparam int unsigned AW_LO   = 0;

  localparam logic [3:0] HALT_SEL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // A HALT is a non-writing instruction whose ALU select is HALT_SEL.
  function automatic logic is_halt(input logic [INSTR_W-1:0] ir);
    return !ir[WE_BIT] && (ir[SEL_HI:SEL_LO] == HALT_SEL);
  endfunction

endpackage

// File: rtl/burrito_pc.sv
// Program counter for the Burrito sequencer: clear, hold, increment, and a
// compare against the last valid instruction index.
module burrito_pc #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  input  logic [PC_W-1:0] last_idx,
  output logic [PC_W-1:0] pc_q,
  output logic            is_last_c
);

  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign is_last_c = (pc_q == last_idx);

endmodule

// File: rtl/burrito_sequencer.sv
// FETCH/DECODE/EXEC/WB instruction sequencer between the program ROM and the
// Burrito datapath. Optional HALT opcode: define BURRITO_SEQ_HALT_OPCODE_EN.
module burrito_sequencer
  import burrito_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = burrito_pkg::INSTR_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Pause,
  input  logic [PC_W-1:0]    ProgLen,
  output logic [PC_W-1:0]    IMemAddr,
  input  logic [INSTR_W-1:0] IMemRdData,
  output logic [INSTR_W-1:0] Instr,
  output logic               Busy,
  output logic               Done,
  output logic [PC_W-1:0]    InstrCount
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    last_q, last_d;
  logic [PC_W-1:0]    cnt_q, cnt_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pc_clr, pc_inc;
  logic [PC_W-1:0]    pc;
  logic               pc_is_last_c;
  logic [INSTR_W-1:0] instr_c;

  burrito_pc #(.PC_W(PC_W)) u_pc (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clr       (pc_clr),
    .inc       (pc_inc),
    .last_idx  (last_q),
    .pc_q      (pc),
    .is_last_c (pc_is_last_c)
  );

  // Next-state and registered-output decode; Pause freezes every busy state.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;

    if (!(Pause && (state_q != ST_IDLE))) begin
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            cnt_d = '0;
            if (ProgLen != '0) begin
              state_d = ST_FETCH;
              pc_clr  = 1'b1;
              addr_d  = '0;
              last_d  = ProgLen - PC_W'(1);
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          ir_d    = IMemRdData;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
`ifdef BURRITO_SEQ_HALT_OPCODE_EN
          state_d = is_halt(ir_q) ? ST_DONE : ST_WB;
`else
          state_d = ST_WB;
`endif
        end
        ST_WB: begin
          cnt_d = cnt_q + PC_W'(1);
          if (pc_is_last_c) begin
            state_d = ST_DONE;
          end else begin
            pc_inc  = 1'b1;
            addr_d  = pc + PC_W'(1);
            state_d = ST_FETCH;
          end
        end
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Write enable only reaches the datapath in an unpaused WB cycle.
  always_comb begin
    instr_c = '0;
    unique case (state_q)
      ST_EXEC: instr_c = {1'b0, ir_q[SEL_HI:AW_LO]};
      ST_WB:   instr_c = {ir_q[WE_BIT] & ~Pause, ir_q[SEL_HI:AW_LO]};
      default: instr_c = '0;
    endcase
  end

  assign Instr      = instr_c;
  assign IMemAddr   = addr_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_burrito_sequencer.sv
// Scoreboard bench for burrito_sequencer: expected write pulses and Done
// events are predicted per run and checked by an independent monitor.
module tb_burrito_sequencer;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               pause = 1'b0;
  logic [PC_W-1:0]    prog_len = '0;
  logic [PC_W-1:0]    addr;
  logic [INSTR_W-1:0] rd_data = '0;
  logic [INSTR_W-1:0] instr;
  logic               busy;
  logic               done;
  logic [PC_W-1:0]    instr_count;

  logic [INSTR_W-1:0] rom [0:255];
  bit                 pz [0:255];

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } ev_t;

  ev_t wq[$];
  ev_t dq[$];
  ev_t me;

  burrito_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Start      (start),
    .Pause      (pause),
    .ProgLen    (prog_len),
    .IMemAddr   (addr),
    .IMemRdData (rd_data),
    .Instr      (instr),
    .Busy       (busy),
    .Done       (done),
    .InstrCount (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data <= rom[addr];
    cyc     <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every write pulse and every Done pulse must match a prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr[19]) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got instr 0x%0h, required none (cycle %0d)", instr, cyc);
        end else begin
          me = wq.pop_front();
          chk("write_cycle", cyc, me.cyc);
          chk("write_instr", 32'(instr), me.val);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got Done=1, required 0 (cycle %0d)", cyc);
        end else begin
          me = dq.pop_front();
          chk("done_cycle", cyc, me.cyc);
          chk("done_count", 32'(instr_count), me.val);
          chk("done_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  function automatic logic [INSTR_W-1:0] rand_word();
    logic [INSTR_W-1:0] w;
    w = INSTR_W'($urandom);
    if ($urandom_range(7) == 0) w = {1'b0, 4'hF, 15'($urandom)};
    return w;
  endfunction

  // One run: predict events from the unpaused-cycle schedule, then drive it.
  // bs_c: 0 = no Start while busy, -1 = random, else that cycle (ProgLen=7).
  task automatic run(input int n, input int bs_c);
    int nexec, done_step, win, step, dc, s0;
    bit halted;
    logic [PC_W-1:0] addr0;
    nexec  = n;
    halted = 1'b0;
`ifdef BURRITO_SEQ_HALT_OPCODE_EN
    for (int k = 0; k < n; k++) begin
      if (!rom[k][19] && rom[k][18:15] == 4'hF) begin
        nexec = k; halted = 1'b1; break;
      end
    end
`endif
    done_step = halted ? 4 * nexec + 4 : 4 * n + 1;
    win = done_step - 1;
    @(posedge clk); #1;
    s0 = int'(cyc);
    addr0 = addr;
    step = 0;
    dc = 0;
    for (int c = 1; c < 256; c++) begin
      if (c <= win && pz[c]) continue;
      step++;
      if (step % 4 == 0 && step / 4 <= nexec && rom[step / 4 - 1][19])
        wq.push_back('{cyc: s0 + c, val: 32'(rom[step / 4 - 1])});
      if (step == done_step) begin
        dq.push_back('{cyc: s0 + c, val: 32'(nexec)});
        dc = c;
        break;
      end
    end
    start = 1'b1;
    prog_len = PC_W'(n);
    for (int c = 1; c <= dc + 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pause = (c <= win) ? pz[c] : 1'b0;
      if (c == bs_c || (bs_c < 0 && c <= win && $urandom_range(4) == 0)) begin
        start = 1'b1;
        prog_len = (bs_c > 0) ? PC_W'(7) : PC_W'($urandom);
      end
      if (n == 0 && c == 1) chk("empty_addr", 32'(addr), 32'(addr0));
      if (c == dc + 1) chk("idle_after_done", 32'(busy), 32'd0);
    end
    start = 1'b0;
    pause = 1'b0;
    chk("final_count", 32'(instr_count), 32'(nexec));
    chk("queues_drained", wq.size() + dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  task automatic clear_pz();
    for (int i = 0; i < 256; i++) pz[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    clear_pz();
    #2;
    chk("rst_instr", 32'(instr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_count", 32'(instr_count), 0);
    #20 rst_n = 1'b1;

    // Normal 3-instruction run.
    rom[0] = 20'h88441; rom[1] = 20'h00000; rom[2] = 20'h89062;
    run(3, 0);

    // Empty program.
    run(0, 0);

    // Pause held across the first WB cycle and two more.
    rom[0] = 20'h8A0A1; rom[1] = 20'h81234;
    pz[4] = 1'b1; pz[5] = 1'b1; pz[6] = 1'b1;
    run(2, 0);
    clear_pz();

    // HALT encoding at ROM[1].
    for (int i = 0; i < 5; i++) rom[i] = 20'h80000 | 20'(i + 1);
    rom[1] = 20'h78000;
    run(5, 0);

    // Start pulse with a different ProgLen while busy.
    for (int i = 0; i < 8; i++) rom[i] = 20'h88000 | 20'(i);
    run(3, 2);

    // Reset asserted in the WB cycle of instruction 1.
    rom[0] = 20'h88441;
    @(posedge clk); #1;
    start = 1'b1; prog_len = 8'd3;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_instr", 32'(instr), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_count", 32'(instr_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(busy), 0);
    end

    // Randomized programs, pauses and busy Start pulses.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(12));
      for (int i = 0; i < 16; i++) rom[i] = rand_word();
      for (int i = 0; i < 256; i++) pz[i] = ($urandom_range(99) < 25);
      run(n, -1);
    end
    clear_pz();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
